serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing Diff = A - B - Bin, LSB first, one bit per clock.
- Uses one full-subtractor cell and a registered borrow flip-flop.
- Sits beside the arithmetic primitives as the low-area companion to the combinational full adder.
- Start/Busy/Done handshake; the result is held until the next operation.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start and operands; the subtractor returns status and result.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b - bin), LSB first, one full-subtractor cell and a borrow flop.
// Latency: done pulses N cycles after the accepting edge; one result every N+1 cycles.
// Backpressure: none; start is taken only in IDLE or DONE and ignored while busy.
module serial_subtractor #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic          load, step, finish;
    logic [N-1:0]  a_sh, b_sh, res_sh;
    logic [N-1:0]  a_nxt, b_nxt, res_nxt;
    logic [N-1:0]  diff_q;
    logic          bout_q, zero_q;
    logic          br, d, br_next;
    logic [CW-1:0] cnt;

    // Full-subtractor cell on the current LSBs and the carried borrow.
    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    always_comb begin
        a_nxt          = a_sh >> 1;
        b_nxt          = b_sh >> 1;
        res_nxt        = res_sh >> 1;
        res_nxt[N-1]   = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A start seen here chains straight into the next operation.
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (load) begin
                a_sh <= bus.a;
                b_sh <= bus.b;
                br   <= bus.bin;
                cnt  <= '0;
            end else if (step) begin
                a_sh   <= a_nxt;
                b_sh   <= b_nxt;
                res_sh <= res_nxt;
                br     <= br_next;
                cnt    <= cnt + CW'(1);
            end
            // Published result only moves on entry to DONE, so it stays put during the next operation.
            if (finish) begin
                diff_q <= res_nxt;
                bout_q <= br_next;
                zero_q <= (res_nxt == '0);
            end
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor at N=4 and N=1.
module tb_serial_subtractor;
    typedef struct {
        int diff;
        int bout;
        int zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   busy_run4 = 0, busy_run1 = 0;
    int   done_cnt4 = 0, done_cnt1 = 0;
    int   last_done4 = 0, prev_done4 = 0, last_done1 = 0;
    int   acc4 = 0, acc1 = 0;

    serial_subtractor_if #(.N(4)) bus4 ();
    serial_subtractor_if #(.N(1)) bus1 ();

    serial_subtractor #(.N(4), .CW(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    serial_subtractor #(.N(1), .CW(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to w bits; borrow means the true result went negative.
    function automatic exp_t model(input int w, input int a, input int b, input int bin);
        exp_t m;
        int   t;
        t      = a - b - bin;
        m.bout = (t < 0) ? 1 : 0;
        m.diff = (t + (1 << w)) % (1 << w);
        m.zero = (m.diff == 0) ? 1 : 0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_run4 = 0;
        end else begin
            if (bus4.busy) busy_run4++;
            if (bus4.done) begin
                check("busy_low_at_done4", int'(bus4.busy), 0);
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done4: got diff=%0d expected no Done", bus4.diff);
                end else begin
                    e4 = q4.pop_front();
                    check("diff4", int'(bus4.diff), e4.diff);
                    check("bout4", int'(bus4.bout), e4.bout);
                    check("zero4", int'(bus4.zero), e4.zero);
                    check("busy_cycles4", busy_run4, 4);
                end
                busy_run4  = 0;
                prev_done4 = last_done4;
                last_done4 = cyc;
                done_cnt4++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            busy_run1 = 0;
        end else begin
            if (bus1.busy) busy_run1++;
            if (bus1.done) begin
                check("busy_low_at_done1", int'(bus1.busy), 0);
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done1: got diff=%0d expected no Done", bus1.diff);
                end else begin
                    e1 = q1.pop_front();
                    check("diff1", int'(bus1.diff), e1.diff);
                    check("bout1", int'(bus1.bout), e1.bout);
                    check("zero1", int'(bus1.zero), e1.zero);
                    check("busy_cycles1", busy_run1, 1);
                end
                busy_run1  = 0;
                last_done1 = cyc;
                done_cnt1++;
            end
        end
    end

    task automatic wait_idle4();
        int k = 0;
        while (bus4.busy && k < 40) begin @(posedge clk); #1; k++; end
        if (bus4.busy) begin
            total++; bad++;
            $display("FAIL timeout_idle4: busy still %0d expected 0", bus4.busy);
        end
    endtask

    task automatic wait_done4();
        int n0 = done_cnt4;
        int k  = 0;
        while (done_cnt4 == n0 && k < 40) begin @(negedge clk); k++; end
        if (done_cnt4 == n0) begin
            total++; bad++;
            $display("FAIL timeout_done4: got no Done in %0d cycles expected one", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done1();
        int n0 = done_cnt1;
        int k  = 0;
        while (done_cnt1 == n0 && k < 20) begin @(negedge clk); k++; end
        if (done_cnt1 == n0) begin
            total++; bad++;
            $display("FAIL timeout_done1: got no Done in %0d cycles expected one", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic op4(input int a, input int b, input int bin);
        wait_idle4();
        bus4.a = 4'(a); bus4.b = 4'(b); bus4.bin = 1'(bin); bus4.start = 1'b1;
        q4.push_back(model(4, a, b, bin));
        @(posedge clk); #1;
        acc4 = cyc;
        bus4.start = 1'b0;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.bin = 1'($urandom);
        wait_done4();
        check("latency4", last_done4 - acc4, 4);
    endtask

    task automatic op1(input int a, input int b, input int bin);
        bus1.a = 1'(a); bus1.b = 1'(b); bus1.bin = 1'(bin); bus1.start = 1'b1;
        q1.push_back(model(1, a, b, bin));
        @(posedge clk); #1;
        acc1 = cyc;
        bus1.start = 1'b0;
        bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.bin = 1'($urandom);
        wait_done1();
        check("latency1", last_done1 - acc1, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
        #2 rst = 1'b1;
        #20;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy4", int'(bus4.busy), 0);
        check("rst_done4", int'(bus4.done), 0);
        check("rst_diff4", int'(bus4.diff), 0);
        check("rst_bout4", int'(bus4.bout), 0);
        check("rst_zero4", int'(bus4.zero), 0);
        check("rst_busy1", int'(bus1.busy), 0);
        check("rst_diff1", int'(bus1.diff), 0);

        // Directed cases from the plan
        op4(9, 3, 0);
        op4(3, 9, 0);
        op4(0, 0, 1);
        op4(5, 5, 0);

        // N=1 truth table
        for (int v = 0; v < 8; v++) op1((v >> 2) & 1, (v >> 1) & 1, v & 1);

        // Start re-pulsed during SHIFT must be ignored
        wait_idle4();
        bus4.a = 4'd12; bus4.b = 4'd7; bus4.bin = 1'b1; bus4.start = 1'b1;
        q4.push_back(model(4, 12, 7, 1));
        @(posedge clk); #1;
        bus4.a = 4'd1; bus4.b = 4'd2; bus4.bin = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        wait_done4();
        n = done_cnt4;
        repeat (10) @(posedge clk);
        #1;
        check("no_extra_done", done_cnt4 - n, 0);

        // Start held through DONE: back-to-back with no IDLE cycle
        wait_idle4();
        bus4.a = 4'd2; bus4.b = 4'd11; bus4.bin = 1'b0; bus4.start = 1'b1;
        q4.push_back(model(4, 2, 11, 0));
        @(posedge clk); #1;
        bus4.a = 4'd14; bus4.b = 4'd3; bus4.bin = 1'b1;
        q4.push_back(model(4, 14, 3, 1));
        n = 0;
        while (!bus4.done && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus4.start = 1'b0;
        wait_done4();
        check("b2b_spacing", last_done4 - prev_done4, 5);

        // Leave a nonzero result with borrow set, then abort mid-operation
        op4(1, 2, 0);
        wait_idle4();
        n = done_cnt4;
        bus4.a = 4'd13; bus4.b = 4'd6; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("busy_before_rst", int'(bus4.busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus4.busy), 0);
        check("abort_done", int'(bus4.done), 0);
        check("abort_diff", int'(bus4.diff), 0);
        check("abort_bout", int'(bus4.bout), 0);
        check("abort_zero", int'(bus4.zero), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt4 - n, 0);
        op4(8, 1, 0);

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 40; i++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            op4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue4_empty", q4.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
